// File: rtl/ts4231_pkg.sv
// Shared encodings for the TS4231 device-side emulator and its host driver.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
//
// Contents: device state encoding, D/E pin phase codes, entry-sequence
// expectation helper, microsecond-to-cycle conversion.
package ts4231_pkg;

  // Device state as seen on dev_state_o; the encoding is shared with the host driver.
  typedef enum logic [2:0] {
    ST_SLEEP   = 3'b000,
    ST_WATCH   = 3'b001,
    ST_S3      = 3'b010,
    ST_S0      = 3'b011,
    ST_UNKNOWN = 3'b100
  } dev_state_e;

  // D carries data, E acts as the clock/strobe of the two-wire bus.
  typedef enum logic {
    PH_DATA = 1'b0,
    PH_CLK  = 1'b1
  } pin_phase_e;

  // Entry sequence: E fall, E rise, E fall, E rise, D fall, D rise.
  localparam logic [2:0] ENTRY_LAST = 3'd5;

  // Which pin the entry matcher expects at a given step.
  function automatic pin_phase_e entry_pin(input logic [2:0] step);
    return (step < 3'd4) ? PH_CLK : PH_DATA;
  endfunction

  // Odd steps expect a rising edge, even steps a falling edge.
  function automatic logic entry_rising(input logic [2:0] step);
    return step[0];
  endfunction

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ts4231_bus_edge.sv
// Registers the resolved D/E bus levels and flags rise/fall on each pin.
// Latency: strobes are combinational against the previous-cycle level.
// Backpressure: none; strobes are single-cycle and must be consumed at once.
//
// Ports: clk, rst_n (async, active low); bus_d_i/bus_e_i resolved levels;
//        d_rise_o/d_fall_o/e_rise_o/e_fall_o single-cycle edge strobes.
module ts4231_bus_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_d_i,
  input  logic bus_e_i,
  output logic d_rise_o,
  output logic d_fall_o,
  output logic e_rise_o,
  output logic e_fall_o
);

  logic d_prev_q;
  logic e_prev_q;

  // Reset level matches the bus with host released and device driving 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev_q <= 1'b0;
      e_prev_q <= 1'b0;
    end else begin
      d_prev_q <= bus_d_i;
      e_prev_q <= bus_e_i;
    end
  end

  assign d_rise_o =  bus_d_i & ~d_prev_q;
  assign d_fall_o = ~bus_d_i &  d_prev_q;
  assign e_rise_o =  bus_e_i & ~e_prev_q;
  assign e_fall_o = ~bus_e_i &  e_prev_q;

endmodule

// File: rtl/ts4231_emulator.sv
// Device-side TS4231 model: tracks sensor state, decodes host D/E sequences, drives idle levels.
// Latency: state changes one cycle after the decoding edge; idle drive follows state one cycle later.
// Backpressure: none; the host bus is free-running, stalls are bounded by the edge timeout.
//
// Ports: clk, rst_n (async, active low); host_{d,e}_i / host_{d,e}_oe_i host pin levels
//        and enables; bus_{d,e}_o resolved bus; light_i/light_data_i light stimulus;
//        dev_state_o state code; cfg_value_o/cfg_valid_o committed config; cfg_err_o abort pulse.
module ts4231_emulator #(
  parameter int unsigned CLK_SPEED  = 50_000_000,
  parameter int unsigned CFG_BITS   = 15,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter logic [15:0] CFG_RESET  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_d_i,
  input  logic        host_d_oe_i,
  input  logic        host_e_i,
  input  logic        host_e_oe_i,
  output logic        bus_d_o,
  output logic        bus_e_o,
  input  logic        light_i,
  input  logic        light_data_i,
  output logic [2:0]  dev_state_o,
  output logic [15:0] cfg_value_o,
  output logic        cfg_valid_o,
  output logic        cfg_err_o
);

  import ts4231_pkg::*;

  localparam int unsigned TO_CYCLES = us_to_cycles(CLK_SPEED, TIMEOUT_US);
  localparam int          TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_CYCLES);
  localparam logic [3:0]      NBITS_C = 4'(CFG_BITS);

  dev_state_e          state_q;
  logic [2:0]          step_q;
  logic                in_frame_q;
  logic [3:0]          bit_cnt_q;
  logic                bit_ovf_q;
  logic [CFG_BITS-1:0] shift_q;
  logic [15:0]         cfg_value_q;
  logic                cfg_valid_q;
  logic                cfg_err_q;
  logic                dev_d_q;
  logic                dev_e_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [TO_W-1:0]     to_cnt_d;

  logic d_rise, d_fall, e_rise, e_fall;

  // Resolved bus: host wins whenever it enables its driver.
  assign bus_d_o = host_d_oe_i ? host_d_i : dev_d_q;
  assign bus_e_o = host_e_oe_i ? host_e_i : dev_e_q;

  ts4231_bus_edge u_bus_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_d_i  (bus_d_o),
    .bus_e_i  (bus_e_o),
    .d_rise_o (d_rise),
    .d_fall_o (d_fall),
    .e_rise_o (e_rise),
    .e_fall_o (e_fall)
  );

  // A D edge coinciding with an E edge is dropped; the E edge wins.
  logic e_edge, any_edge, d_rise_ok, d_fall_ok;
  logic e_drv_edge, d_drv_edge;
  assign e_edge     = e_rise | e_fall;
  assign any_edge   = e_edge | d_rise | d_fall;
  assign d_rise_ok  = d_rise & ~e_edge;
  assign d_fall_ok  = d_fall & ~e_edge;
  assign e_drv_edge = e_edge & host_e_oe_i;
  assign d_drv_edge = (d_rise_ok | d_fall_ok) & host_d_oe_i;

  // Entry matcher: only host-driven edges advance or restart it.
  logic entry_hit, entry_miss;
  always_comb begin
    entry_hit = 1'b0;
    if (entry_pin(step_q) == PH_CLK)
      entry_hit = e_drv_edge && (e_rise == entry_rising(step_q));
    else
      entry_hit = d_drv_edge && (d_rise_ok == entry_rising(step_q));
  end
  assign entry_miss = (e_drv_edge | d_drv_edge) & ~entry_hit;

  logic s3_watch, sleep_watch, frame_start, bit_sample, frame_stop;
  assign s3_watch    = e_rise & host_e_oe_i & ~host_d_oe_i;
  assign sleep_watch = d_fall_ok & host_e_oe_i & ~bus_e_o;
  assign frame_start = d_fall_ok & host_d_oe_i & host_e_oe_i & bus_e_o;
  assign bit_sample  = e_rise & host_e_oe_i;
  assign frame_stop  = d_rise_ok & host_d_oe_i & bus_e_o;

  // Inactivity timeout, only armed while an entry sequence or frame is open.
  logic seq_active, timeout;
  assign seq_active = (step_q != 3'd0) || in_frame_q;
  assign timeout    = seq_active && !any_edge && (to_cnt_q == TO_MAX);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!seq_active || any_edge)
      to_cnt_d = '0;
    else if (to_cnt_q != TO_MAX)
      to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_S0;
      step_q      <= 3'd0;
      in_frame_q  <= 1'b0;
      bit_cnt_q   <= 4'd0;
      bit_ovf_q   <= 1'b0;
      shift_q     <= '0;
      cfg_value_q <= CFG_RESET;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      dev_d_q     <= 1'b0;
      dev_e_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      cfg_err_q <= 1'b0;
      to_cnt_q  <= to_cnt_d;

      // Idle drive tracks the current state, hence lags a transition by one cycle.
      case (state_q)
        ST_SLEEP: {dev_d_q, dev_e_q} <= 2'b10;
        ST_WATCH: {dev_d_q, dev_e_q} <= light_i ? {light_data_i, 1'b0} : 2'b01;
        ST_S3:    {dev_d_q, dev_e_q} <= 2'b11;
        default:  {dev_d_q, dev_e_q} <= 2'b00;
      endcase

      case (state_q)
        ST_S0: begin
          if (light_i) state_q <= ST_S3;
        end

        ST_S3, ST_WATCH: begin
          if (timeout) begin
            step_q    <= 3'd0;
            cfg_err_q <= 1'b1;
          end else if ((state_q == ST_S3) && s3_watch && entry_hit) begin
            // One edge claimed by two decoders: park until reset.
            state_q <= ST_UNKNOWN;
            step_q  <= 3'd0;
          end else if ((state_q == ST_S3) && s3_watch) begin
            state_q <= ST_WATCH;
            step_q  <= 3'd0;
          end else if (entry_hit) begin
            if (step_q == ENTRY_LAST) begin
              state_q <= ST_SLEEP;
              step_q  <= 3'd0;
            end else begin
              step_q <= step_q + 3'd1;
            end
          end else if (entry_miss) begin
            step_q <= 3'd0;
          end
        end

        ST_SLEEP: begin
          if (timeout) begin
            in_frame_q <= 1'b0;
            cfg_err_q  <= 1'b1;
          end else if (!in_frame_q) begin
            if (frame_start) begin
              in_frame_q <= 1'b1;
              bit_cnt_q  <= 4'd0;
              bit_ovf_q  <= 1'b0;
              shift_q    <= '0;
            end else if (sleep_watch) begin
              state_q <= ST_WATCH;
            end
          end else if (bit_sample) begin
            shift_q <= {shift_q[CFG_BITS-2:0], bus_d_o};
            if (bit_cnt_q == 4'hF) bit_ovf_q <= 1'b1;
            else                   bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (frame_stop) begin
            in_frame_q <= 1'b0;
            if ((bit_cnt_q == NBITS_C) && !bit_ovf_q) begin
              cfg_value_q <= 16'(shift_q);
              cfg_valid_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        default: ; // UNKNOWN holds until reset
      endcase
    end
  end

  assign dev_state_o = state_q;
  assign cfg_value_o = cfg_value_q;
  assign cfg_valid_o = cfg_valid_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_ts4231_emulator.sv
// Directed bench for ts4231_emulator: state walk, config frames, timeout and reset.
// Latency: n/a (testbench).
// Backpressure: n/a; frame outcomes go through a scoreboard queue.
`timescale 1ns/1ps
module tb_ts4231_emulator;

  localparam int unsigned CLK_HZ = 10_000_000;  // 10 cycles per microsecond
  localparam int US = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_d, host_d_oe, host_e, host_e_oe;
  logic        bus_d, bus_e;
  logic        light, light_data;
  logic [2:0]  dev_state;
  logic [15:0] cfg_value;
  logic        cfg_valid, cfg_err;

  ts4231_emulator #(
    .CLK_SPEED (CLK_HZ),
    .CFG_BITS  (15),
    .TIMEOUT_US(1000),
    .CFG_RESET (16'h0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_d_i     (host_d),
    .host_d_oe_i  (host_d_oe),
    .host_e_i     (host_e),
    .host_e_oe_i  (host_e_oe),
    .bus_d_o      (bus_d),
    .bus_e_o      (bus_e),
    .light_i      (light),
    .light_data_i (light_data),
    .dev_state_o  (dev_state),
    .cfg_value_o  (cfg_value),
    .cfg_valid_o  (cfg_valid),
    .cfg_err_o    (cfg_err)
  );

  always #50 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int err_cnt = 0;

  always @(negedge clk) if (cfg_err === 1'b1) err_cnt++;

  typedef struct {
    string       tag;
    logic [15:0] value;
    logic        valid;
    int          errs;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic d, input logic doe, input logic e, input logic eoe);
    host_d = d; host_d_oe = doe; host_e = e; host_e_oe = eoe;
  endtask

  task automatic do_entry();
    drive(1'b1, 1'b1, 1'b1, 1'b1); step(US);
    host_e = 1'b0; step(US);
    host_e = 1'b1; step(US);
    host_e = 1'b0; step(US);
    host_e = 1'b1; step(US);
    host_d = 1'b0; step(US);
    host_d = 1'b1; step(3);
  endtask

  // Pop the oldest expected frame outcome and compare against the DUT.
  task automatic sb_check(input int err_base);
    exp_t x;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check({x.tag, "_value"}, 32'(cfg_value), 32'(x.value));
      check({x.tag, "_valid"}, 32'(cfg_valid), 32'(x.valid));
      check({x.tag, "_errs"},  32'(err_cnt - err_base), 32'(x.errs));
    end
  endtask

  // START, nbits MSB-first data bits, then STOP (D low then high while E high).
  task automatic send_frame(input string tag, input logic [15:0] value, input int nbits,
                            input logic [15:0] exp_value, input logic exp_valid, input int exp_errs);
    int base;
    exp_t x;
    x.tag = tag; x.value = exp_value; x.valid = exp_valid; x.errs = exp_errs;
    sb_q.push_back(x);
    base = err_cnt;
    drive(1'b1, 1'b1, 1'b1, 1'b1); step(US);
    host_d = 1'b0; step(US);
    for (int i = nbits - 1; i >= 0; i--) begin
      host_e = 1'b0;     step(5);
      host_d = value[i]; step(5);
      host_e = 1'b1;     step(US);
    end
    host_d = 1'b0; step(5);
    host_d = 1'b1; step(US);
    sb_check(base);
  endtask

  initial begin
    int base;
    exp_t x;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    light = 1'b0; light_data = 1'b0;
    step(3);
    check("rst_state", 32'(dev_state), 32'h3);
    check("rst_bus_d", 32'(bus_d), 32'h0);
    check("rst_bus_e", 32'(bus_e), 32'h0);
    check("rst_value", 32'(cfg_value), 32'h0);
    check("rst_valid", 32'(cfg_valid), 32'h0);
    check("rst_err",   32'(cfg_err), 32'h0);
    rst_n = 1'b1;
    step(5);
    check("s0_idle_state", 32'(dev_state), 32'h3);

    light = 1'b1; step(1);
    light = 1'b0; step(1);
    check("s3_state", 32'(dev_state), 32'h2);
    step(2);
    check("s3_bus_d", 32'(bus_d), 32'h1);
    check("s3_bus_e", 32'(bus_e), 32'h1);

    do_entry();
    check("sleep_state", 32'(dev_state), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); step(3);
    check("sleep_bus_d", 32'(bus_d), 32'h1);
    check("sleep_bus_e", 32'(bus_e), 32'h0);

    send_frame("frame15", 16'h392B, 15, 16'h392B, 1'b1, 0);
    check("frame15_state", 32'(dev_state), 32'h0);
    send_frame("frame14", 16'h1234, 14, 16'h392B, 1'b1, 1);

    // Stall after START: timeout aborts the frame and keeps SLEEP.
    x.tag = "stall"; x.value = 16'h392B; x.valid = 1'b1; x.errs = 1;
    sb_q.push_back(x);
    base = err_cnt;
    host_d = 1'b0; step(20_000);
    sb_check(base);
    check("stall_state", 32'(dev_state), 32'h0);

    // Go-to-watch: D falls while E is driven low, outside a frame.
    host_e = 1'b0; step(US);
    host_d = 1'b1; step(US);
    host_d = 1'b0; step(2);
    check("watch_state", 32'(dev_state), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0); step(3);
    check("watch_bus_d", 32'(bus_d), 32'h0);
    check("watch_bus_e", 32'(bus_e), 32'h1);
    light = 1'b1; light_data = 1'b1; step(2);
    check("env1_bus_d", 32'(bus_d), 32'h1);
    check("env1_bus_e", 32'(bus_e), 32'h0);
    light_data = 1'b0; step(2);
    check("env0_bus_d", 32'(bus_d), 32'h0);
    check("env0_bus_e", 32'(bus_e), 32'h0);
    light = 1'b0; step(2);
    check("envoff_bus_e", 32'(bus_e), 32'h1);

    // Re-enter SLEEP from WATCH, open a frame, then reset mid-frame.
    do_entry();
    check("reentry_state", 32'(dev_state), 32'h0);
    base = err_cnt;
    host_d = 1'b0; step(US);
    host_e = 1'b0; step(5);
    host_d = 1'b1; step(5);
    host_e = 1'b1; step(5);
    rst_n = 1'b0; step(1);
    check("midrst_state", 32'(dev_state), 32'h3);
    check("midrst_value", 32'(cfg_value), 32'h0);
    check("midrst_valid", 32'(cfg_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; step(3);
    check("post_rst_state", 32'(dev_state), 32'h3);
    check("post_rst_bus", 32'({bus_d, bus_e}), 32'h0);
    check("post_rst_errs", 32'(err_cnt - base), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
